// File: rtl/mult_div_seq_if.sv
// Start/mode handshake and HI/LO result bundle between the control unit and mult_div_seq.
// The control unit drives the master side; the multiply/divide unit is the slave.
interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             MDCtrl;
  logic             sgn;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, MDCtrl, sgn, opA, opB,
    input  hi, lo, busy, done, div0
  );

  modport slave (
    input  start, MDCtrl, sgn, opA, opB,
    output hi, lo, busy, done, div0
  );
endinterface

// File: rtl/mult_div_seq.sv
// Sequential shift-add multiply / restoring divide unit with HI/LO result registers.
// Define MD_SIGNED_EN to add signed operand handling (magnitude conversion and sign fix-up).
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_seq_if.slave  md
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opReg_q, opReg_d;
  logic                 isDiv_q, isDiv_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;
`ifdef MD_SIGNED_EN
  logic                 negRes_q, negRes_d;
  logic                 negRem_q, negRem_d;
`endif

  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       remShift;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     magA, magB;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     quotFix, remFix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opReg_d  = opReg_q;
    isDiv_d  = isDiv_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;

    // acc holds {partial product, multiplier} or {remainder, quotient}; opReg holds multiplicand or divisor
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opReg_q} : '0);
    remShift = acc_q[2*WIDTH-1:WIDTH-1];
    trial    = remShift - {1'b0, opReg_q};

    magA     = md.opA;
    magB     = md.opB;
    prodFix  = acc_q;
    quotFix  = acc_q[WIDTH-1:0];
    remFix   = acc_q[2*WIDTH-1:WIDTH];
`ifdef MD_SIGNED_EN
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    if (md.sgn) begin
      if (md.opA[WIDTH-1]) magA = -md.opA;
      if (md.opB[WIDTH-1]) magB = -md.opB;
    end
    if (negRes_q) begin
      prodFix = -acc_q;
      quotFix = -acc_q[WIDTH-1:0];
    end
    if (negRem_q) remFix = -acc_q[2*WIDTH-1:WIDTH];
`endif

    case (state_q)
      IDLE: begin
        if (md.start) begin
          state_d = CALC;
          cnt_d   = '0;
          busy_d  = 1'b1;
          isDiv_d = md.MDCtrl;
          zero_d  = md.MDCtrl && (md.opB == '0);
          opReg_d = md.MDCtrl ? magB : magA;
          acc_d   = {{WIDTH{1'b0}}, (md.MDCtrl ? magA : magB)};
`ifdef MD_SIGNED_EN
          negRes_d = md.sgn & (md.opA[WIDTH-1] ^ md.opB[WIDTH-1]);
          negRem_d = md.sgn & md.opA[WIDTH-1];
`endif
        end
      end
      CALC: begin
        if (zero_q) begin
          state_d = FIX;
        end else begin
          // trial[WIDTH] set means the subtraction went negative, so the shifted remainder is kept
          if (isDiv_q) begin
            acc_d = trial[WIDTH] ? {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        div0_d  = zero_q;
        if (!zero_q) begin
          if (isDiv_q) begin
            hi_d = remFix;
            lo_d = quotFix;
          end else begin
            {hi_d, lo_d} = prodFix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opReg_q  <= '0;
      isDiv_q  <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
`ifdef MD_SIGNED_EN
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opReg_q  <= opReg_d;
      isDiv_q  <= isDiv_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
`ifdef MD_SIGNED_EN
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
`endif
    end
  end

  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.div0 = div0_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: a 32-bit unit driven from a vector table plus
// hand sequences for busy/back-to-back behaviour, and an 8-bit unit for mid-operation reset.
module tb_mult_div_seq;

  logic clk = 1'b0;
  logic reset;
  logic reset8;
  int   total = 0;
  int   bad   = 0;

  mult_div_seq_if #(.WIDTH(32)) bus32();
  mult_div_seq_if #(.WIDTH(8))  bus8();

  mult_div_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset),  .md(bus32));
  mult_div_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8), .md(bus8));

  always #5 clk = ~clk;

  typedef struct {
    logic        mdCtrl;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDiv0;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic m, input logic s, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] h,
                              input logic [31:0] l, input logic z, input int lat);
    vec_t v;
    v.mdCtrl = m; v.sgn = s; v.a = a; v.b = b;
    v.expHi = h; v.expLo = l; v.expDiv0 = z; v.expLat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus32(input logic m, input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
    @(negedge clk);
    bus32.start = 1'b1; bus32.MDCtrl = m; bus32.sgn = s; bus32.opA = a; bus32.opB = b;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start = 1'b1; bus8.MDCtrl = 1'b0; bus8.sgn = 1'b0; bus8.opA = a; bus8.opB = b;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
  endtask

  task automatic waitDone32(output int n, output int drops);
    n = 0;
    drops = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!bus32.done && !bus32.busy) drops++;
    end while (!bus32.done && n < 200);
    checkOutput("done32_seen", 64'(bus32.done), 64'd1);
  endtask

  task automatic waitDone8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus8.done && n < 100);
    checkOutput("done8_seen", 64'(bus8.done), 64'd1);
  endtask

  initial begin
    int n, drops, n2, spurious;

    vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 33));
    vecs.push_back(mk(0, 0, 32'd3,        32'd5,        32'h0,        32'd15,       0, 33));
    vecs.push_back(mk(1, 0, 32'd9,        32'd0,        32'h0,        32'd15,       1, 2));
    vecs.push_back(mk(1, 0, 32'd100,      32'd7,        32'd2,        32'd14,       0, 33));
    vecs.push_back(mk(0, 0, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 0, 33));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF, 0, 33));
    vecs.push_back(mk(1, 0, 32'd5,        32'd9,        32'd5,        32'h0,        0, 33));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        0, 33));
    vecs.push_back(mk(0, 0, 32'h80000000, 32'h2,        32'h1,        32'h0,        0, 33));
    vecs.push_back(mk(1, 0, 32'hDEADBEEF, 32'h10,       32'hF,        32'h0DEADBEE, 0, 33));
`ifdef MD_SIGNED_EN
    vecs.push_back(mk(1, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33));
    vecs.push_back(mk(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 0, 33));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 33));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'd16,       0, 33));
    vecs.push_back(mk(1, 1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0, 33));
`else
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 0, 33));
    vecs.push_back(mk(1, 1, 32'hFFFFFFF9, 32'd2,        32'h1,        32'h7FFFFFFC, 0, 33));
`endif

    reset = 1'b0; reset8 = 1'b0;
    bus32.start = 1'b0; bus32.MDCtrl = 1'b0; bus32.sgn = 1'b0; bus32.opA = '0; bus32.opB = '0;
    bus8.start  = 1'b0; bus8.MDCtrl  = 1'b0; bus8.sgn  = 1'b0; bus8.opA  = '0; bus8.opB  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; reset8 = 1'b1;
    checkOutput("rst_hi",   64'(bus32.hi),   64'd0);
    checkOutput("rst_lo",   64'(bus32.lo),   64'd0);
    checkOutput("rst_busy", 64'(bus32.busy), 64'd0);
    checkOutput("rst_done", 64'(bus32.done), 64'd0);
    checkOutput("rst_div0", 64'(bus32.div0), 64'd0);

    foreach (vecs[i]) begin
      applyStimulus32(vecs[i].mdCtrl, vecs[i].sgn, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("v%0d_busy_start", i), 64'(bus32.busy), 64'd1);
      waitDone32(n, drops);
      checkOutput($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].expLat));
      checkOutput($sformatf("v%0d_busy_hold", i), 64'(drops), 64'd0);
      checkOutput($sformatf("v%0d_hi", i), 64'(bus32.hi), 64'(vecs[i].expHi));
      checkOutput($sformatf("v%0d_lo", i), 64'(bus32.lo), 64'(vecs[i].expLo));
      checkOutput($sformatf("v%0d_div0", i), 64'(bus32.div0), 64'(vecs[i].expDiv0));
      checkOutput($sformatf("v%0d_busy_end", i), 64'(bus32.busy), 64'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_done_pulse", i), 64'(bus32.done), 64'd0);
      checkOutput($sformatf("v%0d_div0_pulse", i), 64'(bus32.div0), 64'd0);
    end

    // A start pulse in the middle of CALC must not disturb the running multiply
    applyStimulus32(1'b0, 1'b0, 32'h00010001, 32'h3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b1; bus32.MDCtrl = 1'b1; bus32.opA = 32'd1; bus32.opB = 32'd1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    waitDone32(n, drops);
    checkOutput("midstart_latency", 64'(n + 10), 64'd33);
    checkOutput("midstart_hi", 64'(bus32.hi), 64'd0);
    checkOutput("midstart_lo", 64'(bus32.lo), 64'h00030003);
    @(posedge clk);
    #1;

    // Start held high: the second operation is taken at the first IDLE edge
    @(negedge clk);
    bus32.start = 1'b1; bus32.MDCtrl = 1'b0; bus32.sgn = 1'b0; bus32.opA = 32'd6; bus32.opB = 32'd7;
    @(posedge clk);
    #1;
    bus32.MDCtrl = 1'b1; bus32.opA = 32'd100; bus32.opB = 32'd7;
    waitDone32(n, drops);
    checkOutput("b2b_first_latency", 64'(n), 64'd33);
    checkOutput("b2b_first_hi", 64'(bus32.hi), 64'd0);
    checkOutput("b2b_first_lo", 64'(bus32.lo), 64'd42);
    waitDone32(n2, drops);
    bus32.start = 1'b0;
    checkOutput("b2b_done_gap", 64'(n2), 64'd34);
    checkOutput("b2b_second_hi", 64'(bus32.hi), 64'd2);
    checkOutput("b2b_second_lo", 64'(bus32.lo), 64'd14);

    // 8-bit unit: preload, abort 200x200 at iteration 4, then rerun it
    applyStimulus8(8'd3, 8'd5);
    waitDone8(n);
    checkOutput("w8_pre_latency", 64'(n), 64'd9);
    checkOutput("w8_pre_lo", 64'(bus8.lo), 64'd15);
    applyStimulus8(8'd200, 8'd200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset8 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("w8_rst_hi",   64'(bus8.hi),   64'd0);
    checkOutput("w8_rst_lo",   64'(bus8.lo),   64'd0);
    checkOutput("w8_rst_busy", 64'(bus8.busy), 64'd0);
    checkOutput("w8_rst_done", 64'(bus8.done), 64'd0);
    checkOutput("w8_rst_div0", 64'(bus8.div0), 64'd0);
    @(negedge clk);
    reset8 = 1'b1;
    spurious = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus8.done || bus8.busy) spurious++;
    end
    checkOutput("w8_stays_idle", 64'(spurious), 64'd0);
    applyStimulus8(8'd200, 8'd200);
    waitDone8(n);
    checkOutput("w8_latency", 64'(n), 64'd9);
    checkOutput("w8_hi", 64'(bus8.hi), 64'h9C);
    checkOutput("w8_lo", 64'(bus8.lo), 64'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Parametrised sequential multiply/divide unit with HI/LO result registers. It is the next-generation replacement for the datapath's fixed 32-bit multiply/divide path, sitting between the register-file read ports and the HI/LO-to-register path. The microcoded control unit drives it with a start/mode handshake and waits on `busy`/`done`. It runs iterative shift-add multiply and restoring divide over a configurable operand width, with optional signed mode and divide-by-zero flagging.

## Interface
- `WIDTH`, default 32: operand width in bits; must be ≥ 4. HI and LO are each WIDTH bits.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width. Derived; do not override.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begin operation; sampled only in IDLE.
- `MDCtrl`, input, 1: operation select; 0 = multiply, 1 = divide. Sampled with `start`.
- `sgn`, input, 1: 1 = signed operands. Sampled with `start`. Ignored unless `MD_SIGNED_EN` is defined.
- `opA`, input, WIDTH: multiplicand or dividend. Sampled with `start`.
- `opB`, input, WIDTH: multiplier or divisor. Sampled with `start`.
- `hi`, output, WIDTH: product upper half, or remainder.
- `lo`, output, WIDTH: product lower half, or quotient.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse; `hi`/`lo` were updated this cycle, or a div-by-zero completed.
- `div0`, output, 1: one-cycle pulse coincident with `done` when a divide had `opB` == 0.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 at a clock edge latches the operands, `MDCtrl` and `sgn` into internal registers, then moves to CALC with the counter at 0.
  - `start` is ignored in any other state; there is no queueing.
- **Divide by zero**
  - A divide with `opB`=0 moves straight to FIX with the zero flag set and skips all iterations.
  - In FIX it asserts `done`=1 and `div0`=1, leaves `hi`/`lo` unchanged, and returns to IDLE.
- **CALC**
  - Performs one iteration per cycle for WIDTH cycles, then moves to FIX.
  - Multiply: 2·WIDTH-bit accumulator; if the multiplier LSB is set, add the multiplicand to the upper half; then shift the accumulator right by 1.
  - Divide: restoring divide. Shift the {remainder, quotient} pair left by 1. Trial-subtract the divisor using a WIDTH+1-bit subtractor; if the result is non-negative, keep it and set quotient LSB = 1.
- **FIX**
  - Applies the sign correction, writes `hi`/`lo`, pulses `done`, and returns to IDLE.
  - Multiply result: {`hi`,`lo`} = 2·WIDTH-bit product.
  - Divide result: `lo` = quotient, `hi` = remainder.
- **Arithmetic**
  - Intermediate values are never truncated below WIDTH+1 bits.
  - Unsigned results are exact modulo 2^(2·WIDTH) for multiply.
- **Reset** (`reset`=0 at an edge, in any state, including mid-CALC)
  - Aborts the operation and returns to IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div0`=0; counter and internal registers cleared.

## Timing
- Let E0 be the edge at which `start` is accepted.
- `busy`=1 from after E0 until after the edge that enters IDLE.
  - `busy` is a registered output and is 0 in IDLE.
- Normal operation:
  - Iterations occur at edges E1..E(WIDTH).
  - FIX is the state after E(WIDTH). The edge E(WIDTH+1) writes `hi`/`lo`, sets `done`=1, sets `busy`=0, and enters IDLE.
  - Latency from E0 to results visible is WIDTH+1 cycles. `done` is high for exactly one cycle, then clears at E(WIDTH+2).
- Divide by zero: `done`=`div0`=1 after E2 for one cycle; latency is 2 cycles.
- Back-to-back: a `start` held high at E(WIDTH+2), the first edge in IDLE, is accepted. The maximum issue rate is one operation per WIDTH+2 cycles.
- `hi`/`lo` hold their values between operations and during CALC. They change only at FIX or reset.
- Operand inputs may change freely after E0.

## Configuration
- `MD_SIGNED_EN` defined:
  - With `sgn`=1, operands are converted to magnitudes at E0, with the sign bits latched.
  - In FIX:
    - the product is negated if the operand signs differ;
    - the quotient is negated if the signs differ;
    - the remainder takes the dividend's sign.
  - Most-negative ÷ −1 yields `lo`=most-negative (wraps) and `hi`=0; no flag is raised.
  - Latency is unchanged.
- `MD_SIGNED_EN` undefined:
  - The `sgn` input is ignored and all operations are unsigned.
  - No negation logic is synthesised.

## Test plan
All scenarios use WIDTH=32 unless stated.
- **Reset:** `reset`=0 for 2 cycles, then release.
  - Response: `hi`=`lo`=0, `busy`=`done`=`div0`=0.
- **Unsigned multiply:** `start`, `MDCtrl`=0, `opA`=0xFFFFFFFF, `opB`=0xFFFFFFFF.
  - Response: after 33 cycles, `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulse of 1 cycle, `busy` high for 33 cycles.
- **Signed divide** (`MD_SIGNED_EN` defined): `MDCtrl`=1, `sgn`=1, `opA`=−7, `opB`=2.
  - Response: `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
  - Repeat with `opA`=0x80000000, `opB`=0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Divide by zero:** preload `hi`/`lo` via 3×5, then divide 9 by 0.
  - Response: `done`=`div0`=1 after 2 cycles; `hi`=0, `lo`=15 unchanged.
- **Start while busy, then back-to-back:**
  - Pulse `start` mid-CALC: it is ignored and the result matches the first operation.
  - Hold `start` high through completion: the second operation is accepted at the first IDLE edge, and its `done` arrives 34 cycles after the first `done`.
- **Reset mid-operation, with WIDTH=8:**
  - Assert `reset` at iteration 4 of 200×200: the unit returns to IDLE and all outputs are 0.
  - A new 200×200 then yields `hi`=0x9C, `lo`=0x40.
